// File: rtl/ovi_pkg.sv
// ovi_pkg: shared OVI link types and constants.
// Holds the bus structs exchanged between the scalar core, the issue
// controller and the vector unit, plus the link-wide width constants.
package ovi_pkg;

  localparam int OVI_SBID_WIDTH        = 5;
  localparam int OVI_VSTART_WIDTH      = 14;
  localparam int OVI_ISSUE_CREDITS_MAX = 16;
  localparam int OVI_VL_WIDTH          = 15;
  localparam int OVI_DATA_WIDTH        = 64;

  // Vector CSR snapshot travelling with each issued instruction.
  typedef struct packed {
    logic [OVI_VSTART_WIDTH-1:0] vstart;
    logic [OVI_VL_WIDTH-1:0]     vl;
    logic [1:0]                  vxrm;
    logic [2:0]                  frm;
    logic [2:0]                  vlmul;
    logic [2:0]                  vsew;
    logic                        vill;
  } v_csr;

  typedef struct packed {
    logic [31:0]             instr;
    logic [OVI_VL_WIDTH-1:0] vl;
    logic [2:0]              sew;
    logic                    valid;
  } core_issue_bus;

  typedef struct packed {
    logic [OVI_DATA_WIDTH-1:0] data;
    logic                      valid;
  } core_completed_bus;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               instr;
    logic [OVI_DATA_WIDTH-1:0] scalar_opnd;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    v_csr                      csr;
  } vpu_issue_bus;

  typedef struct packed {
    logic                      next_senior;
    logic                      kill;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
  } vpu_dispatch_bus;

  typedef struct packed {
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    logic [OVI_DATA_WIDTH-1:0] dest_reg;
    logic                      valid;
  } vpu_completed_bus;

  typedef struct packed {
    logic                      sync_end;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
  } vpu_memop_bus;

  typedef struct packed {
    logic                      valid;
    logic                      mask_valid;
    logic [OVI_DATA_WIDTH-1:0] data;
    logic [OVI_SBID_WIDTH-1:0] seq_id;
  } vpu_load_bus;

endpackage

// File: rtl/ovi_sbid_fifo.sv
// ovi_sbid_fifo: in-order queue of in-flight scoreboard IDs.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, din     : enqueue din (taken when not full, or full but popping)
//   pop           : dequeue head (ignored when empty)
//   head          : oldest entry, combinational
//   count         : number of entries
//   full, empty   : status decoded from count
module ovi_sbid_fifo #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 do_push, do_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(DEPTH - 1)) return '0;
    return p + PTR_WIDTH'(1);
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_WIDTH'(DEPTH));
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  // A push into a full queue is legal when the head leaves on the same edge:
  // the slot being written is the one being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - CNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ovi_issue_ctrl.sv
// ovi_issue_ctrl: core-side OVI issue/completion controller.
// Allows up to MAX_OUTSTANDING vector instructions in flight, tags each with
// a wrapping scoreboard ID and checks completions against the issue order.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   CORE_ISSUE          : instruction from the core (instr, vl, sew, valid)
//   CORE_FENCE          : hold new issues until nothing is in flight
//   CORE_COMPLETED(_SBID): registered completion report to the core
//   CORE_HALT           : issue cannot be accepted this cycle
//   PROTO_ERR           : sticky protocol error
//   VPU_ISSUE_CREDIT    : one issue credit returned by the vector unit
//   VPU_COMPLETED       : completion from the vector unit
//   VPU_ISSUE/DISPATCH  : combinational issue and in-order dispatch
//   VPU_MEMOP/LOAD/MASK_IDX_CREDIT : unused channels, tied off
module ovi_issue_ctrl import ovi_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ISSUE_CREDITS   = 4,
  parameter int SBID_WIDTH      = OVI_SBID_WIDTH,
  parameter int CREDIT_WIDTH    = $clog2(ISSUE_CREDITS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  core_issue_bus         CORE_ISSUE,
  input  logic                  CORE_FENCE,
  output core_completed_bus     CORE_COMPLETED,
  output logic [SBID_WIDTH-1:0] CORE_COMPLETED_SBID,
  output logic                  CORE_HALT,
  output logic                  PROTO_ERR,
  input  logic                  VPU_ISSUE_CREDIT,
  input  vpu_completed_bus      VPU_COMPLETED,
  output vpu_issue_bus          VPU_ISSUE,
  output vpu_dispatch_bus       VPU_DISPATCH,
  output vpu_memop_bus          VPU_MEMOP,
  output vpu_load_bus           VPU_LOAD,
  output logic                  VPU_MASK_IDX_CREDIT
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
  logic [SBID_WIDTH-1:0]   sbid_ctr_reg;
  logic                    proto_err_reg;
  core_completed_bus       completed_reg;
  logic [SBID_WIDTH-1:0]   completed_sbid_reg;

  logic [SBID_WIDTH-1:0]   fifo_head;
  logic [CNT_WIDTH-1:0]    fifo_count;
  logic                    fifo_full, fifo_empty;

  logic can_issue, accept;
  logic cpl_pop, cpl_err, credit_overflow;

  // All conditions use state from the previous edge, so a completion popping
  // a full queue does not unblock issue until the following cycle.
  assign can_issue = (credits_reg != '0) && !fifo_full
                     && !(CORE_FENCE && (fifo_count != '0));
  assign accept    = CORE_ISSUE.valid && can_issue;
  assign CORE_HALT = !can_issue;

  // No bypass: a completion arriving with an empty queue is an error even if
  // an issue is being pushed in the same cycle.
  assign cpl_pop = VPU_COMPLETED.valid && !fifo_empty;
  assign cpl_err = VPU_COMPLETED.valid &&
                   (fifo_empty || (OVI_SBID_WIDTH'(fifo_head) != VPU_COMPLETED.sb_id));

  ovi_sbid_fifo #(
    .WIDTH    (SBID_WIDTH),
    .DEPTH    (MAX_OUTSTANDING),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_sbid_fifo (
    .clk  (CLK),
    .rst_n(RST_N),
    .push (accept),
    .pop  (cpl_pop),
    .din  (sbid_ctr_reg),
    .head (fifo_head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Credit counter: accept consumes, return refills, both together cancel.
  // A refill beyond the reset value saturates and is reported.
  always_comb begin
    credits_next    = credits_reg;
    credit_overflow = 1'b0;
    case ({accept, VPU_ISSUE_CREDIT})
      2'b10: credits_next = credits_reg - CREDIT_WIDTH'(1);
      2'b01: begin
        if (credits_reg == CREDIT_WIDTH'(ISSUE_CREDITS)) credit_overflow = 1'b1;
        else                                              credits_next = credits_reg + CREDIT_WIDTH'(1);
      end
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      credits_reg        <= CREDIT_WIDTH'(ISSUE_CREDITS);
      sbid_ctr_reg       <= '0;
      proto_err_reg      <= 1'b0;
      completed_reg      <= '0;
      completed_sbid_reg <= '0;
    end else begin
      credits_reg         <= credits_next;
      if (accept) sbid_ctr_reg <= sbid_ctr_reg + SBID_WIDTH'(1);
      proto_err_reg       <= proto_err_reg | cpl_err | credit_overflow;
      completed_reg.valid <= VPU_COMPLETED.valid;
      if (VPU_COMPLETED.valid) begin
        completed_reg.data <= VPU_COMPLETED.dest_reg;
        completed_sbid_reg <= VPU_COMPLETED.sb_id[SBID_WIDTH-1:0];
      end
    end
  end

  assign CORE_COMPLETED      = completed_reg;
  assign CORE_COMPLETED_SBID = completed_sbid_reg;
  assign PROTO_ERR           = proto_err_reg;

  always_comb begin
    VPU_ISSUE          = '0;
    VPU_ISSUE.valid    = accept;
    VPU_ISSUE.instr    = CORE_ISSUE.instr;
    VPU_ISSUE.sb_id    = OVI_SBID_WIDTH'(sbid_ctr_reg);
    VPU_ISSUE.csr.vl   = CORE_ISSUE.vl;
    VPU_ISSUE.csr.vsew = CORE_ISSUE.sew;

    VPU_DISPATCH             = '0;
    VPU_DISPATCH.next_senior = accept;
    VPU_DISPATCH.sb_id       = OVI_SBID_WIDTH'(sbid_ctr_reg);
  end

  assign VPU_MEMOP           = '0;
  assign VPU_LOAD            = '0;
  assign VPU_MASK_IDX_CREDIT = 1'b0;

endmodule

// File: tb/tb_ovi_issue_ctrl.sv
// Bench for ovi_issue_ctrl. Instance 0 uses default parameters (4 in flight,
// 4 credits, 5-bit IDs); instance 1 uses 2 in flight, 4 credits, 3-bit IDs.
// Each step drives one instance, checks combinational outputs before the next
// edge and checks the registered completion against a scoreboard queue.
module tb_ovi_issue_ctrl;
  import ovi_pkg::*;

  typedef struct {
    bit         iv, fence, cred, cv;
    logic [4:0] csb;
    bit         halt, ivalid;
    logic [4:0] isb;
    bit         err;
  } vec_t;

  typedef struct packed {
    logic [4:0]  sbid;
    logic [63:0] data;
  } cpl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_issue_bus     i_iss  [2];
  logic              i_fence[2];
  logic              i_cred [2];
  vpu_completed_bus  i_cpl  [2];
  core_completed_bus o_cc   [2];
  logic [4:0]        o_ccsb [2];
  logic              o_halt [2];
  logic              o_err  [2];
  vpu_issue_bus      o_iss  [2];
  vpu_dispatch_bus   o_disp [2];
  vpu_memop_bus      o_memop[2];
  vpu_load_bus       o_load [2];
  logic              o_mic  [2];
  logic [2:0]        ccsb_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  cpl_t sbq0[$];
  cpl_t sbq1[$];
  bit   prev_cpl[2];
  vec_t tbl[22];

  ovi_issue_ctrl dut_a (
    .CLK(clk), .RST_N(rst_n), .CORE_ISSUE(i_iss[0]), .CORE_FENCE(i_fence[0]),
    .CORE_COMPLETED(o_cc[0]), .CORE_COMPLETED_SBID(o_ccsb[0]), .CORE_HALT(o_halt[0]),
    .PROTO_ERR(o_err[0]), .VPU_ISSUE_CREDIT(i_cred[0]), .VPU_COMPLETED(i_cpl[0]),
    .VPU_ISSUE(o_iss[0]), .VPU_DISPATCH(o_disp[0]), .VPU_MEMOP(o_memop[0]),
    .VPU_LOAD(o_load[0]), .VPU_MASK_IDX_CREDIT(o_mic[0])
  );

  ovi_issue_ctrl #(.MAX_OUTSTANDING(2), .ISSUE_CREDITS(4), .SBID_WIDTH(3)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CORE_ISSUE(i_iss[1]), .CORE_FENCE(i_fence[1]),
    .CORE_COMPLETED(o_cc[1]), .CORE_COMPLETED_SBID(ccsb_b), .CORE_HALT(o_halt[1]),
    .PROTO_ERR(o_err[1]), .VPU_ISSUE_CREDIT(i_cred[1]), .VPU_COMPLETED(i_cpl[1]),
    .VPU_ISSUE(o_iss[1]), .VPU_DISPATCH(o_disp[1]), .VPU_MEMOP(o_memop[1]),
    .VPU_LOAD(o_load[1]), .VPU_MASK_IDX_CREDIT(o_mic[1])
  );
  assign o_ccsb[1] = {2'b00, ccsb_b};

  function automatic vec_t mk(int iv, int fe, int cr, int cv, int csb,
                              int h, int ivd, int isb, int e);
    vec_t r;
    r.iv = (iv != 0); r.fence = (fe != 0); r.cred = (cr != 0); r.cv = (cv != 0);
    r.csb = 5'(csb); r.halt = (h != 0); r.ivalid = (ivd != 0); r.isb = 5'(isb);
    r.err = (e != 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      i_iss[k] = '0; i_fence[k] = 1'b0; i_cred[k] = 1'b0; i_cpl[k] = '0;
    end
  endtask

  // One cycle of stimulus on instance d, then check before the next edge.
  task automatic apply(input int d, input vec_t v, input string name);
    cpl_t e;
    cpl_t got;
    @(posedge clk);
    #1;
    idle_inputs();
    i_iss[d].valid = v.iv;
    i_iss[d].instr = $urandom;
    i_iss[d].vl    = OVI_VL_WIDTH'($urandom);
    i_iss[d].sew   = 3'($urandom);
    i_fence[d]     = v.fence;
    i_cred[d]      = v.cred;
    i_cpl[d].valid = v.cv;
    i_cpl[d].sb_id = v.csb;
    i_cpl[d].dest_reg = {$urandom, $urandom};
    if (v.cv) begin
      e.sbid = v.csb;
      e.data = i_cpl[d].dest_reg;
      if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
    end
    @(negedge clk);
    chk({name, ".halt"}, 128'(o_halt[d]), 128'(v.halt));
    chk({name, ".issue_valid"}, 128'(o_iss[d].valid), 128'(v.ivalid));
    chk({name, ".next_senior"}, 128'(o_disp[d].next_senior), 128'(v.ivalid));
    chk({name, ".kill"}, 128'(o_disp[d].kill), 128'(0));
    if (v.ivalid) begin
      chk({name, ".issue_sbid"}, 128'(o_iss[d].sb_id), 128'(v.isb));
      chk({name, ".dispatch_sbid"}, 128'(o_disp[d].sb_id), 128'(v.isb));
      chk({name, ".issue_fields"},
          128'({o_iss[d].instr, o_iss[d].csr.vl, o_iss[d].csr.vsew}),
          128'({i_iss[d].instr, i_iss[d].vl, i_iss[d].sew}));
      chk({name, ".issue_zero"},
          128'({o_iss[d].scalar_opnd, o_iss[d].csr.vstart, o_iss[d].csr.vxrm,
                o_iss[d].csr.frm, o_iss[d].csr.vlmul, o_iss[d].csr.vill}), 128'(0));
    end
    chk({name, ".proto_err"}, 128'(o_err[d]), 128'(v.err));
    chk({name, ".tieoff"}, 128'({o_memop[d].sync_end, o_load[d].valid,
                                 o_load[d].mask_valid, o_mic[d]}), 128'(0));
    if (prev_cpl[d]) begin
      if (d == 0) got = sbq0.pop_front(); else got = sbq1.pop_front();
      chk({name, ".cpl_valid"}, 128'(o_cc[d].valid), 128'(1));
      chk({name, ".cpl_sbid"}, 128'(o_ccsb[d]), 128'(got.sbid));
      chk({name, ".cpl_data"}, 128'(o_cc[d].data), 128'(got.data));
    end else begin
      chk({name, ".cpl_idle"}, 128'(o_cc[d].valid), 128'(0));
    end
    prev_cpl[d] = v.cv;
  endtask

  // Asynchronous reset asserted between edges; optionally checks that the
  // sticky state clears without waiting for a clock edge.
  task automatic do_reset(input bit check_async);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    if (check_async) begin
      chk("async_rst.proto_err", 128'(o_err[0]), 128'(0));
      chk("async_rst.halt", 128'(o_halt[0]), 128'(0));
      chk("async_rst.cpl_valid", 128'(o_cc[0].valid), 128'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sbq0.delete();
    sbq1.delete();
    prev_cpl[0] = 1'b0;
    prev_cpl[1] = 1'b0;
  endtask

  initial begin
    //            iv fe cr cv csb  halt ivd isb err
    tbl[0]  = mk(1, 0, 0, 0, 0,   0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,   0, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0,   0, 1, 2, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0,   0, 1, 3, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0,   1, 0, 0, 0);  // out of credits and queue full
    tbl[5]  = mk(1, 0, 1, 0, 0,   1, 0, 0, 0);  // credit lands next cycle
    tbl[6]  = mk(1, 0, 0, 1, 0,   1, 0, 0, 0);  // full queue blocks despite pop
    tbl[7]  = mk(1, 0, 1, 1, 1,   0, 1, 4, 0);  // accept+credit, accept+pop
    tbl[8]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0);  // credits and count unchanged
    tbl[9]  = mk(1, 0, 0, 0, 0,   0, 1, 5, 0);
    tbl[10] = mk(0, 0, 0, 1, 2,   1, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0,   1, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 3,   0, 1, 6, 0);
    tbl[13] = mk(0, 0, 0, 1, 9,   1, 0, 0, 0);  // head is 4: mismatch
    tbl[14] = mk(0, 0, 0, 0, 0,   1, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 0,   1, 0, 0, 1);
    tbl[16] = mk(0, 0, 1, 0, 0,   0, 0, 0, 1);
    tbl[17] = mk(1, 1, 0, 1, 5,   1, 0, 0, 1);  // fence with 2 in flight
    tbl[18] = mk(1, 1, 0, 1, 6,   1, 0, 0, 1);  // fence with 1 in flight
    tbl[19] = mk(1, 1, 0, 0, 0,   0, 1, 7, 1);  // drained: fence lets issue go
    tbl[20] = mk(0, 0, 0, 1, 7,   0, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1);

    idle_inputs();
    prev_cpl[0] = 1'b0;
    prev_cpl[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_iss[0].valid = 1'b1;
    #1;
    chk("reset.halt", 128'(o_halt[0]), 128'(0));
    chk("reset.issue_follows_valid", 128'(o_iss[0].valid), 128'(1));
    chk("reset.issue_sbid", 128'(o_iss[0].sb_id), 128'(0));
    chk("reset.proto_err", 128'(o_err[0]), 128'(0));
    chk("reset.cpl", 128'({o_cc[0].valid, o_cc[0].data, o_ccsb[0]}), 128'(0));
    i_iss[0].valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) apply(0, tbl[i], $sformatf("a%0d", i));

    // Mid-run reset clears the error and restores 4 credits and sb_id 0.
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) apply(0, mk(1, 0, 0, 0, 0, 0, 1, k, 0), $sformatf("fill%0d", k));
    apply(0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0), "fill_halt");

    // Completion on an empty queue, even alongside an accept.
    do_reset(1'b0);
    apply(0, mk(1, 0, 0, 1, 0, 0, 1, 0, 0), "empty_cpl");
    apply(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "empty_cpl_err");

    // Fifth credit return with all credits held.
    do_reset(1'b0);
    apply(0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0), "over_credit");
    apply(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "over_credit_err");

    // Queue-limited halt with 2 in flight and credits left.
    do_reset(1'b0);
    apply(1, mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "qlim0");
    apply(1, mk(1, 0, 0, 0, 0, 0, 1, 1, 0), "qlim1");
    apply(1, mk(1, 0, 0, 0, 0, 1, 0, 0, 0), "qlim_halt");
    apply(1, mk(1, 0, 0, 1, 0, 1, 0, 0, 0), "qlim_pop");
    apply(1, mk(1, 0, 0, 0, 0, 0, 1, 2, 0), "qlim_resume");
    apply(1, mk(0, 0, 0, 0, 0, 1, 0, 0, 0), "qlim_full");

    // 3-bit ID wrap: ten issues, each completed and credited one cycle later.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++)
      apply(1, mk(1, 0, (i > 0), (i > 0), (i > 0) ? (i - 1) % 8 : 0, 0, 1, i % 8, 0),
            $sformatf("wrap%0d", i));
    apply(1, mk(0, 0, 1, 1, 1, 0, 0, 0, 0), "wrap_last");
    apply(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
